// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer
//   Sits between the UART core and the combinational ALU. It collects three
//   received bytes in order (opcode, operand A, operand B) and presents them
//   to the ALU as registered operands. It then captures the ALU result and
//   hands that byte to the UART transmitter. The next opcode is accepted only
//   after the transmitter reports completion, so one operation runs at a time.
//
// Build option:
//   SEQ_TIMEOUT_EN - when defined, a stall of TIMEOUT_CLKS clocks while
//                    waiting for operand A or B raises o_err and returns the
//                    sequencer to IDLE. When undefined, no counter is built
//                    and the operand states wait indefinitely.
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_rx_done     one-cycle tick: i_rx_data holds a received byte
//   i_rx_data     received byte
//   i_tx_done     one-cycle tick: transmitter finished the stop bit
//   o_tx_start    one-cycle pulse: start transmitting o_tx_data
//   o_tx_data     byte to transmit, held from o_tx_start until i_tx_done
//   o_alu_a       registered operand A
//   o_alu_b       registered operand B
//   o_alu_op      registered opcode (low OP_WIDTH bits of the opcode byte)
//   i_alu_result  combinational ALU result
//   o_busy        high in any state other than IDLE
//   o_err         one-cycle pulse on an invalid opcode or an inter-byte timeout
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for the opcode byte
// WAIT_A  | opcode accepted, waiting for operand A
// WAIT_B  | operand A accepted, waiting for operand B
// EXEC    | operands stable for one cycle, capture the ALU result
// SEND    | o_tx_start asserted for this single cycle
// WAIT_TX | transmitter running, waiting for i_tx_done
module alu_uart_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OP_WIDTH     = 6,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_A  = 3'd1;
  localparam logic [2:0] S_WAIT_B  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;

  // Opcodes are matched on the full received byte, so 0x60 (which shares
  // its low six bits with 0x20) is rejected.
  localparam logic [DATA_WIDTH-1:0] OPC_ADD = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] OPC_SUB = DATA_WIDTH'(8'h22);
  localparam logic [DATA_WIDTH-1:0] OPC_AND = DATA_WIDTH'(8'h24);
  localparam logic [DATA_WIDTH-1:0] OPC_OR  = DATA_WIDTH'(8'h25);
  localparam logic [DATA_WIDTH-1:0] OPC_XOR = DATA_WIDTH'(8'h26);
  localparam logic [DATA_WIDTH-1:0] OPC_SRA = DATA_WIDTH'(8'h03);
  localparam logic [DATA_WIDTH-1:0] OPC_SRL = DATA_WIDTH'(8'h02);
  localparam logic [DATA_WIDTH-1:0] OPC_NOR = DATA_WIDTH'(8'h27);

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [OP_WIDTH-1:0]   r_alu_op;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_err;
  logic                  w_op_valid;
  logic                  w_in_wait;
  logic                  w_tmo_hit;

  always_comb begin
    w_op_valid = 1'b0;
    case (i_rx_data)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_XOR, OPC_SRA, OPC_SRL, OPC_NOR: w_op_valid = 1'b1;
      default:                            w_op_valid = 1'b0;
    endcase
  end

  assign w_in_wait = (r_state == S_WAIT_A) || (r_state == S_WAIT_B);

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;

  // Expires on the cycle the count sits at TIMEOUT_CLKS-1, so o_err rises
  // TIMEOUT_CLKS clocks after the byte that opened the wait.
  assign w_tmo_hit = w_in_wait && (r_tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

  // Counts only while waiting for an operand. An accepted byte restarts the
  // count, and any exit from the wait states (including timeout) clears it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tmo_cnt <= '0;
    end else if (w_in_wait && !i_rx_done && !w_tmo_hit) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  logic w_unused_tmo;

  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CLKS == 0) && w_in_wait;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_tx_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_done) begin
            if (w_op_valid) begin
              r_alu_op <= i_rx_data[OP_WIDTH-1:0];
              r_state  <= S_WAIT_A;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        // An arriving byte takes priority over a timeout in the same cycle.
        S_WAIT_A: begin
          if (i_rx_done) begin
            r_alu_a <= i_rx_data;
            r_state <= S_WAIT_B;
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_WAIT_B: begin
          if (i_rx_done) begin
            r_alu_b <= i_rx_data;
            r_state <= S_EXEC;
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        // Operand B was registered on the previous edge, so the ALU has had
        // a full cycle with stable inputs before its result is captured.
        S_EXEC: begin
          r_tx_data <= i_alu_result;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          r_state <= S_WAIT_TX;
        end
        // Received bytes are dropped here. A simultaneous tx_done still
        // completes the operation.
        S_WAIT_TX: begin
          if (i_tx_done) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx_start = (r_state == S_SEND);
  assign o_tx_data  = r_tx_data;
  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_busy     = (r_state != S_IDLE);
  assign o_err      = r_err;

endmodule
